// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the CPU data bus.
// A 16-byte window at BASE_ADDR holds two registers:
//   +0x0 TXDATA (write-only)  byte pushed into the transmit FIFO
//   +0x4 STATUS (read-only)   {24'b0, fill[3:0], overflow, busy, empty, full}
// Reads return their data one cycle later, matching the ram blocks.
// Ports:
//   clk       system clock (the divided CPU clock)
//   reset     synchronous, active-high reset
//   address   CPU byte address
//   data_in   CPU write data
//   write     CPU write strobe
//   data_out  registered read data
//   tx        serial line, idle high, always driven from a flop
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write,
  output logic [31:0] data_out,
  output logic        tx
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bus decode
  logic       sel;
  logic [3:0] off;
  logic       wr_q;
  logic       wr_ev;
  logic       rd_ev;
  logic       rd_status;

  assign sel       = (address[31:4] == BASE_ADDR[31:4]);
  assign off       = address[3:0];
  // Only the rising edge of the strobe pushes, so a held write pushes once.
  assign wr_ev     = write && sel && (off == 4'h0) && !wr_q;
  assign rd_ev     = sel && !write;
  assign rd_status = rd_ev && (off == 4'h4);

  // Upper write-data bits are not used by this block.
  logic unused_bits;
  assign unused_bits = ^data_in[31:8];

  // FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               overflow;

  // count never exceeds DEPTH, so its MSB alone flags full.
  assign full  = count[FIFO_AW];
  assign empty = (count == '0);

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;

  // Pop is based on the registered count, so a byte pushed into an empty
  // FIFO can only be popped on the following edge.
  assign pop  = (state == IDLE) && !empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push = wr_ev && (!full || pop);

  // NOTE: storage has no reset; pointers and count define validity, and
  // leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[7:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      wr_q <= write;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Write and read are mutually exclusive (write strobe vs !write).
      if (wr_ev && !push)  overflow <= 1'b1;
      else if (rd_status)  overflow <= 1'b0;
    end
  end

  // Status word and registered read port
  logic [31:0] count_w;
  logic [3:0]  fill;
  logic [31:0] status;

  assign count_w = 32'(count);
  assign fill    = (count_w > 32'd15) ? 4'hf : count_w[3:0];
  assign status  = {24'h0, fill, overflow, (state != IDLE), empty, full};

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (rd_ev) begin
      data_out <= rd_status ? status : 32'h0;
    end
  end

  // Transmit FSM: each phase lasts BIT_LAST+1 cycles, bit_cnt counting down.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      idx     <= '0;
      sh      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            sh      <= mem[rd_ptr];
            tx      <= 1'b0;
            bit_cnt <= BIT_LAST;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == 16'd0) begin
            tx      <= sh[0];
            idx     <= 3'd0;
            bit_cnt <= BIT_LAST;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_cnt == 16'd0) begin
            bit_cnt <= BIT_LAST;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx  <= sh[idx + 3'd1];
              idx <= idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_cnt == 16'd0) state <= IDLE;
          else                  bit_cnt <= bit_cnt - 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx with CLKS_PER_BIT=4 and an 8-deep FIFO.
// Bytes written are pushed into exp_q; a line monitor decodes each frame
// on tx and pops/compares against exp_q.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE      = 32'h0000_2000;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_1000;
  localparam int          CPB       = 4;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write;
  logic [31:0] data_out;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data_in (data_in),
    .write   (write),
    .data_out(data_out),
    .tx      (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_cnt = 0;
  int extra_frames = 0;
  logic mon_busy = 1'b0;

  logic [7:0] exp_q[$];
  int         starts_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) rst_cnt = rst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line monitor: samples on falling edges, mid-bit.
  initial begin
    logic [7:0] got;
    int         r0;
    forever begin
      @(negedge clk);
      if (reset || tx !== 1'b0) continue;
      mon_busy = 1'b1;
      r0 = rst_cnt;
      starts_q.push_back(cyc);
      repeat (2) @(negedge clk);
      if (rst_cnt == r0) check("start_bit", 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        got[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (rst_cnt == r0) begin
        check("stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() > 0) check("rx_byte", 32'(got), 32'(exp_q.pop_front()));
        else extra_frames++;
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_pulse(input logic [31:0] a, input logic [7:0] d, input int len);
    @(negedge clk);
    address = a;
    data_in = {24'hABCDEF, d};
    write   = 1'b1;
    repeat (len) @(negedge clk);
    write   = 1'b0;
    address = IDLE_ADDR;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = data_out;
    address = IDLE_ADDR;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  fb;
    int          n;

    reset = 1'b1; address = IDLE_ADDR; data_in = '0; write = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_data_out", data_out, 32'h0);

    // 1: single byte, exact waveform
    starts_q.delete();
    exp_q.push_back(8'h68);
    write_pulse(BASE, 8'h68, 1);
    check("t1_pre_pop", 32'(tx), 32'd1);
    fb = {1'b1, 8'h68, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      check($sformatf("t1_wave%0d", k), 32'(tx), 32'(fb[k / CPB]));
    end
    @(negedge clk);
    check("t1_idle_after", 32'(tx), 32'd1);
    wait_drain("t1_drain", 200);
    check("t1_frames", 32'(starts_q.size()), 32'd1);

    // 2: "hello", 2-cycle strobes, back-to-back frames
    starts_q.delete();
    foreach (fb[i]) ; // no-op keeps fb scoped use simple
    begin
      logic [7:0] msg [5];
      msg = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f};
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back(msg[i]);
        write_pulse(BASE, msg[i], 2);
      end
    end
    wait_drain("t2_drain", 600);
    check("t2_frames", 32'(starts_q.size()), 32'd5);
    for (int i = 1; i < starts_q.size(); i++)
      check($sformatf("t2_gap%0d", i), 32'(starts_q[i] - starts_q[i-1]), 32'd41);

    // 3: held strobe pushes once
    starts_q.delete();
    exp_q.push_back(8'h41);
    write_pulse(BASE, 8'h41, 10);
    wait_drain("t3_drain", 200);
    repeat (60) @(negedge clk);
    check("t3_frames", 32'(starts_q.size()), 32'd1);

    // 4: overflow with 10 pulses into an 8-deep FIFO
    starts_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'h30 + 8'(i));
      write_pulse(BASE, 8'h30 + 8'(i), 1);
    end
    read_reg(BASE + 32'h4, rd);
    check("t4_status_ovf", rd, 32'h0000_008D);
    read_reg(BASE + 32'h4, rd);
    check("t4_status_clr", rd, 32'h0000_0085);
    wait_drain("t4_drain", 1000);
    repeat (60) @(negedge clk);
    check("t4_frames", 32'(starts_q.size()), 32'd9);

    // 5: read port behaviour after reset
    do_reset(2);
    check("t5_reset_data_out", data_out, 32'h0);
    read_reg(BASE + 32'h4, rd);
    check("t5_status_idle", rd, 32'h0000_0002);
    read_reg(32'h0000_3004, rd);
    check("t5_outside_hold", rd, 32'h0000_0002);
    read_reg(BASE + 32'h8, rd);
    check("t5_offset8", rd, 32'h0);

    // 6: reset mid-frame with 3 bytes queued
    starts_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h51 + 8'(i));
      write_pulse(BASE, 8'h51 + 8'(i), 1);
    end
    repeat (8) @(negedge clk);
    check("t6_mid_frame", 32'(starts_q.size()), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("t6_tx_after_reset", 32'(tx), 32'd1);
    read_reg(BASE + 32'h4, rd);
    check("t6_status", rd, 32'h0000_0002);
    n = 0;
    while (mon_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_mon_idle", 32'(n < 100), 32'd1);
    starts_q.delete();
    repeat (200) @(negedge clk);
    check("t6_no_frames", 32'(starts_q.size()), 32'd0);
    check("t6_tx_idle", 32'(tx), 32'd1);

    check("extra_frames", 32'(extra_frames), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
